// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one byte to the keyboard: inhibit, start bit, 8 data bits, odd parity, stop, device ACK.
// Both PS/2 lines are open-drain; this block only outputs the low-enables clkps2_oe and dataps2_oe.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 3640,   // 130 us at 28 MHz
  parameter int unsigned TIMEOUT_CYCLES = 560000, // 20 ms at 28 MHz
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       system_reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       ps2_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       clkps2_in,
  input  logic       dataps2_in,
  output logic       clkps2_oe,
  output logic       dataps2_oe
);

  localparam int unsigned INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);

  localparam logic [INH_W-1:0]  INH_LOAD  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RELEASE,
    S_SHIFT,
    S_ACK,
    S_WAITHI
  } state_e;

  state_e              state_q;
  logic [1:0]          clk_sync_q;
  logic [1:0]          data_sync_q;
  logic                filt_q;
  logic                filt_d;
  logic [FILT_W-1:0]   filt_cnt_q;
  logic [FILT_W-1:0]   filt_cnt_d;
  logic                fe;
  logic [8:0]          shift_q;     // {parity, data}, shifted out LSB first
  logic [3:0]          bit_cnt_q;   // falling edges consumed so far
  logic [INH_W-1:0]    inh_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                clk_oe_q;
  logic                data_oe_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  // Two-flop synchronisers for both raw pin levels; idle bus level is high.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value; blocking here would collapse the chain.
      clk_sync_q  <= {clk_sync_q[0], clkps2_in};
      data_sync_q <= {data_sync_q[0], dataps2_in};
    end
  end

  // Deglitcher next state: accept a new clock level after FILTER_LEN consecutive differing samples.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end
  end

  assign fe = filt_q & ~filt_d;

  // Deglitcher state registers.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Transmit FSM with registered line enables and status pulses.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            shift_q   <= {~^tx_data, tx_data};
            bit_cnt_q <= '0;
            inh_cnt_q <= INH_LOAD;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt_q == '0) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;       // start bit
            to_cnt_q  <= TO_LOAD;
            state_q   <= S_RELEASE;
          end else begin
            inh_cnt_q <= inh_cnt_q - INH_W'(1);
          end
        end
        S_RELEASE, S_SHIFT, S_ACK, S_WAITHI: begin
          if (!fe && to_cnt_q == '0) begin
            // Device went quiet: give the bus back and report failure.
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            to_cnt_q <= fe ? TO_LOAD : to_cnt_q - TO_W'(1);
            case (state_q)
              S_RELEASE: begin
                if (fe) begin
                  data_oe_q <= ~shift_q[0];
                  shift_q   <= {1'b0, shift_q[8:1]};
                  bit_cnt_q <= 4'd1;
                  state_q   <= S_SHIFT;
                end
              end
              S_SHIFT: begin
                if (fe) begin
                  if (bit_cnt_q == 4'd9) begin
                    data_oe_q <= 1'b0;   // stop bit: line released
                    state_q   <= S_ACK;
                  end else begin
                    data_oe_q <= ~shift_q[0];
                    shift_q   <= {1'b0, shift_q[8:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
                end
              end
              S_ACK: begin
                if (fe) begin
                  if (!data_sync_q[1]) begin
                    state_q <= S_WAITHI;
                  end else begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                  end
                end
              end
              S_WAITHI: begin
                if (filt_q && data_sync_q[1]) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign clkps2_oe  = clk_oe_q;
  assign dataps2_oe = data_oe_q;
  assign ps2_busy   = busy_q;
  assign tx_done    = done_q;
  assign tx_err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int TIMEOUT = 3000;
  localparam int HALF    = 40;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       system_reset_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2_busy, tx_done, tx_err;
  logic       clkps2_in, dataps2_in, clkps2_oe, dataps2_oe;
  logic       dev_clk, dev_data;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic busy_prev = 1'b0, busy_at_pulse = 1'b1, busy_before_pulse = 1'b0;

  always #5 clk = ~clk;

  // Wired-AND open-drain bus: host pulls low via oe, device via its own drive.
  assign clkps2_in  = dev_clk  & ~clkps2_oe;
  assign dataps2_in = dev_data & ~dataps2_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(3640),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN(8)
  ) dut (
    .clk(clk),
    .system_reset_n(system_reset_n),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .ps2_busy(ps2_busy),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .clkps2_in(clkps2_in),
    .dataps2_in(dataps2_in),
    .clkps2_oe(clkps2_oe),
    .dataps2_oe(dataps2_oe)
  );

  // Pulse monitor.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err)  err_cnt  <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (tx_done || tx_err) begin
      busy_at_pulse     <= ps2_busy;
      busy_before_pulse <= busy_prev;
    end
    busy_prev <= ps2_busy;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Counts cycles of host clock inhibit, returns at the first cycle with the clock released.
  task automatic wait_release(output int n);
    n = 0;
    while (clkps2_oe === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("release_seen", clkps2_oe, 1'b0);
  endtask

  // Device: sample start bit, clock 10 bits sampling on rising edges, then the ACK clock.
  task automatic dev_frame(input bit ack, input bit glitch, output logic [10:0] smp);
    smp = '0;
    repeat (20) @(negedge clk);
    smp[0] = dataps2_in;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      @(negedge clk);
      smp[i] = dataps2_in;
      if (glitch && i == 4) begin
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 14) @(negedge clk);
      end else begin
        repeat (HALF - 1) @(negedge clk);
      end
    end
    if (ack) dev_data = 1'b0;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int d0, e0;
    logic [10:0] smp;

    system_reset_n = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_busy", ps2_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", tx_err, 1'b0);
    check("rst_clk_oe", clkps2_oe, 1'b0);
    check("rst_data_oe", dataps2_oe, 1'b0);
    system_reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // 0xED with ACK: inhibit length, bit order, parity, done/busy timing.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    check("ed_busy_accept", ps2_busy, 1'b1);
    wait_release(n);
    check("ed_inhibit_len", n, 3640);
    check("ed_start_driven", dataps2_oe, 1'b1);
    dev_frame(1'b1, 1'b0, smp);
    wait_end(d0, e0);
    check("ed_bits", smp, 11'h7DA);
    check("ed_done", done_cnt - d0, 1);
    check("ed_no_err", err_cnt - e0, 0);
    check("ed_busy_before", busy_before_pulse, 1'b1);
    check("ed_busy_at_done", busy_at_pulse, 1'b0);
    check("ed_lines_free", {clkps2_oe, dataps2_oe}, 2'b00);

    // 0x00 (parity 1); a second request during inhibit must be ignored.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h00);
    start_tx(8'hAA);
    wait_release(n);
    dev_frame(1'b1, 1'b0, smp);
    wait_end(d0, e0);
    check("x00_bits", smp, 11'h600);
    check("x00_done", done_cnt - d0, 1);

    // 0x01 (parity 0).
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h01);
    wait_release(n);
    dev_frame(1'b1, 1'b0, smp);
    wait_end(d0, e0);
    check("x01_bits", smp, 11'h402);
    check("x01_done", done_cnt - d0, 1);

    // Silent device: timeout counted from RELEASE entry.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h55);
    wait_release(n);
    n = 0;
    while (tx_err !== 1'b1 && n < TIMEOUT + 500) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, TIMEOUT);
    check("to_lines_free", {clkps2_oe, dataps2_oe}, 2'b00);
    check("to_busy", ps2_busy, 1'b0);
    repeat (5) @(negedge clk);
    check("to_lines_stay_free", {clkps2_oe, dataps2_oe}, 2'b00);
    check("to_err", err_cnt - e0, 1);
    check("to_no_done", done_cnt - d0, 0);

    // Device never ACKs.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF3);
    wait_release(n);
    dev_frame(1'b0, 1'b0, smp);
    wait_end(d0, e0);
    check("nack_err", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);

    // 3-cycle clock glitch must not create a falling edge.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hA5);
    wait_release(n);
    dev_frame(1'b1, 1'b1, smp);
    wait_end(d0, e0);
    check("glitch_bits", smp, 11'h74A);
    check("glitch_done", done_cnt - d0, 1);

    // Reset in the middle of SHIFT, after falling edge 4.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h12);
    wait_release(n);
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_data_oe_bit3", dataps2_oe, 1'b1);
    check("mid_busy", ps2_busy, 1'b1);
    system_reset_n = 1'b0;
    #1;
    check("mid_rst_lines", {clkps2_oe, dataps2_oe}, 2'b00);
    check("mid_rst_busy", ps2_busy, 1'b0);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    system_reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // Normal frame after the reset.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF);
    wait_release(n);
    dev_frame(1'b1, 1'b0, smp);
    wait_end(d0, e0);
    check("xff_bits", smp, 11'h7FE);
    check("xff_done", done_cnt - d0, 1);
    check("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the send side of the keyboard link, complementing the existing keyboard receiver.
- Sends command/data bytes to the keyboard, e.g. 0xED LED set, 0xFF reset, 0xF3 typematic.
- Runs on the 28 MHz system clock.
- Drives the open-drain PS/2 clock and data lines through low-enable outputs; the top level builds the tristates.
- While busy, the receiver is blanked via ps2_busy so it ignores our own frame.

Parameters:
- INHIBIT_CYCLES, 3640: host holds clock low this long before the start bit (130 us at 28 MHz).
- TIMEOUT_CYCLES, 560000: maximum wait for any device clock edge (20 ms at 28 MHz).
- FILTER_LEN, 8: consecutive equal samples required to accept a new clock level.

Ports:
- clk  in  1  system clock, 28 MHz
- system_reset_n  in  1  asynchronous active-low reset
- tx_start  in  1  one-cycle request; accepted only when ps2_busy=0
- tx_data  in  8  byte to send; latched on accepted tx_start
- ps2_busy  out  1  high from the cycle after acceptance until done/err
- tx_done  out  1  one-cycle pulse: frame sent and device ACK seen
- tx_err  out  1  one-cycle pulse: timeout or missing ACK
- clkps2_in  in  1  raw PS/2 clock pin level
- dataps2_in  in  1  raw PS/2 data pin level
- clkps2_oe  out  1  1 = drive PS/2 clock low, 0 = release
- dataps2_oe  out  1  1 = drive PS/2 data low, 0 = release

Behaviour:
- Reset (async, system_reset_n=0):
  - state=IDLE, all outputs 0, lines released.
  - Counters cleared; filtered clock level = 1.
- Input conditioning:
  - clkps2_in and dataps2_in pass through 2-flop synchronisers.
  - Clock is then deglitched: level changes only after FILTER_LEN identical samples.
  - A falling edge (fe) is a one-cycle strobe when the filtered level goes 1->0.
- Frame: start 0, 8 data bits LSB first, odd parity (parity = ~^tx_data), stop 1, device ACK 0.
- IDLE:
  - On tx_start: latch tx_data, compute parity, clear bit counter, load inhibit counter, go INHIBIT.
  - tx_start while busy is ignored; no queueing.
- INHIBIT:
  - clkps2_oe=1, dataps2_oe=0 for INHIBIT_CYCLES cycles.
  - On the last cycle, set dataps2_oe=1 (start bit) and go RELEASE.
- RELEASE:
  - clkps2_oe=0, dataps2_oe stays 1.
  - Timeout counter reloads; wait for fe, then go SHIFT.
- SHIFT:
  - Data-line value is changed only on fe; the device samples on the rising edge.
  - fe #1..#8: dataps2_oe = ~bit[n], n=0..7.
  - fe #9: dataps2_oe = ~parity.
  - fe #10: dataps2_oe=0 (stop, line released); go ACK.
- ACK:
  - On fe #11, sample synced data.
  - Data 0: go WAITHI.
  - Data 1: pulse tx_err, go IDLE.
- WAITHI:
  - Wait for filtered clock=1 AND synced data=1.
  - Then pulse tx_done, go IDLE.
- Timeout:
  - In RELEASE/SHIFT/ACK/WAITHI the counter reloads on every fe.
  - Expiry: release both lines, pulse tx_err, go IDLE.
- ps2_busy: 1 in every state except IDLE; drops in the same cycle tx_done/tx_err pulse.
- tx_done and tx_err are never high together; each lasts exactly one cycle.
- Mid-frame reset: lines released immediately (async), state IDLE, no pulse issued.
- clkps2_oe and dataps2_oe are registered; no combinational path from inputs.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz that ACKs.
  - clkps2_oe low for exactly 3640 cycles.
  - Device-sampled bits: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device then drives ACK=0; tx_done pulses once; ps2_busy falls the same cycle.
- Send 0x00: parity bit sampled =1; send 0x01: parity =0; both end with tx_done.
- Device model never clocks after release:
  - tx_err pulses 560000 cycles after RELEASE entry.
  - clkps2_oe=0 and dataps2_oe=0 from then on.
- Device clocks all 11 edges but leaves data high at the ACK edge: tx_err pulses, no tx_done.
- 3-cycle glitch low on clkps2_in during SHIFT: no fe generated, bit order unchanged, tx_done at end.
- Assert system_reset_n=0 mid-SHIFT after fe #4:
  - Both oe outputs 0 the same cycle; ps2_busy=0.
  - Next tx_start of 0xFF completes a normal frame.
